// File: rtl/button_event.sv
//------------------------------------------------------------------------------
// Module : button_event
// Brief  : Converts a debounced button level into press, release, long-press
//          and double-click pulses, and keeps a wrapping press counter.
//          Optional feature macro: BUTTON_EVENT_DOUBLE_CLICK_EN (GAP state and
//          double-click detection).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event #(
    parameter int CLK_FREQUENCY   = 100_000_000,
    parameter int LONG_PRESS_US   = 20,
    parameter int DOUBLE_CLICK_US = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       debounced,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       double_click,
    output logic [7:0] press_count
);

    localparam int LONG_CLOCKS = CLK_FREQUENCY / 1_000_000 * LONG_PRESS_US;
    localparam int DC_CLOCKS   = CLK_FREQUENCY / 1_000_000 * DOUBLE_CLICK_US;
    localparam int MAX_CLOCKS  = (LONG_CLOCKS > DC_CLOCKS) ? LONG_CLOCKS : DC_CLOCKS;
    localparam int CNT_W       = (MAX_CLOCKS > 1) ? $clog2(MAX_CLOCKS + 1) : 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLOCKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t           state_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic [7:0]       count_q;

    logic w_rise;
    logic w_fall;

    assign w_rise = debounced & ~prev_q;
    assign w_fall = ~debounced & prev_q;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DC_CLOCKS - 1);

    logic dc_q;
    // Set while the current press is itself the second click, so its release
    // cannot open another double-click window.
    logic from_dc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            dc_q      <= 1'b0;
            from_dc_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            prev_q    <= debounced;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            dc_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        state_q   <= S_PRESSED;
                        cnt_q     <= '0;
                        press_q   <= 1'b1;
                        from_dc_q <= 1'b0;
                        count_q   <= count_q + 8'd1;
                    end
                end
                S_PRESSED: begin
                    if (w_fall) begin
                        release_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= from_dc_q ? S_IDLE : S_GAP;
                    end else if (cnt_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= S_HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (w_fall) begin
                        release_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (w_rise) begin
                        state_q   <= S_PRESSED;
                        cnt_q     <= '0;
                        press_q   <= 1'b1;
                        dc_q      <= 1'b1;
                        from_dc_q <= 1'b1;
                        count_q   <= count_q + 8'd1;
                    end else if (cnt_q == DC_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign double_click = dc_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            prev_q    <= debounced;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end
                end
                S_PRESSED: begin
                    if (w_fall) begin
                        release_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= S_HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (w_fall) begin
                        release_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign double_click = 1'b0;
`endif

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign press_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event.sv
//------------------------------------------------------------------------------
// Module : tb_button_event
// Brief  : Directed vector bench for button_event at 100 MHz (LONG 2000 cycles,
//          double-click window 1000 cycles).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    localparam int DCX = 1;
`else
    localparam int DCX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       debounced;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       double_click;
    logic [7:0] press_count;

    button_event #(
        .CLK_FREQUENCY  (100_000_000),
        .LONG_PRESS_US  (20),
        .DOUBLE_CLICK_US(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .debounced    (debounced),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .double_click (double_click),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse tallies taken on the falling edge, away from the active edge.
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0, n_dc = 0;
    int press_cyc = 0, long_cyc = 0;
    int overlap = 0, dc_alone = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (press_pulse) begin
            n_press   = n_press + 1;
            press_cyc = cyc;
        end
        if (release_pulse) n_rel = n_rel + 1;
        if (long_press) begin
            n_long   = n_long + 1;
            long_cyc = cyc;
        end
        if (double_click) n_dc = n_dc + 1;
        if (press_pulse && release_pulse) overlap = overlap + 1;
        if (double_click && !press_pulse) dc_alone = dc_alone + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int h0, l0, h1, l1, h2, l2;
        int e_press, e_rel, e_long, e_dc;
        bit chk_lat;
    } vec_t;

    vec_t vecs[11];
    int   exp_count;

    initial begin
        vecs[0]  = '{500,  1100, 0,   0,    0,   0,    1, 1, 0, 0,   1'b0};
        vecs[1]  = '{3000, 1100, 0,   0,    0,   0,    1, 1, 1, 0,   1'b1};
        vecs[2]  = '{1990, 1100, 0,   0,    0,   0,    1, 1, 0, 0,   1'b0};
        vecs[3]  = '{2010, 1100, 0,   0,    0,   0,    1, 1, 1, 0,   1'b1};
        vecs[4]  = '{200,  400,  200, 1100, 0,   0,    2, 2, 0, DCX, 1'b0};
        vecs[5]  = '{200,  1200, 200, 1100, 0,   0,    2, 2, 0, 0,   1'b0};
        vecs[6]  = '{2500, 400,  200, 1100, 0,   0,    2, 2, 1, 0,   1'b0};
        vecs[7]  = '{100,  100,  100, 100,  100, 1100, 3, 3, 0, DCX, 1'b0};
        vecs[8]  = '{200,  990,  200, 1100, 0,   0,    2, 2, 0, DCX, 1'b0};
        vecs[9]  = '{200,  1010, 200, 1100, 0,   0,    2, 2, 0, 0,   1'b0};
        vecs[10] = '{200,  400,  2500, 1100, 0,  0,    2, 2, 1, DCX, 1'b0};

        rst       = 1'b1;
        debounced = 1'b0;
        step(3);
        chk("rst_press",   int'(press_pulse),   0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_long",    int'(long_press),    0);
        chk("rst_dc",      int'(double_click),  0);
        chk("rst_count",   int'(press_count),   0);
        rst       = 1'b0;
        exp_count = 0;
        step(5);

        for (int i = 0; i < 11; i++) begin
            int sp, sr, sl, sd;
            sp = n_press; sr = n_rel; sl = n_long; sd = n_dc;
            debounced = 1'b1; step(vecs[i].h0);
            debounced = 1'b0; step(vecs[i].l0);
            if (vecs[i].h1 > 0) begin
                debounced = 1'b1; step(vecs[i].h1);
                debounced = 1'b0; step(vecs[i].l1);
            end
            if (vecs[i].h2 > 0) begin
                debounced = 1'b1; step(vecs[i].h2);
                debounced = 1'b0; step(vecs[i].l2);
            end
            exp_count = (exp_count + vecs[i].e_press) % 256;
            chk($sformatf("v%0d_press", i),   n_press - sp, vecs[i].e_press);
            chk($sformatf("v%0d_release", i), n_rel - sr,   vecs[i].e_rel);
            chk($sformatf("v%0d_long", i),    n_long - sl,  vecs[i].e_long);
            chk($sformatf("v%0d_dc", i),      n_dc - sd,    vecs[i].e_dc);
            chk($sformatf("v%0d_count", i),   int'(press_count), exp_count);
            if (vecs[i].chk_lat)
                chk($sformatf("v%0d_long_latency", i), long_cyc - press_cyc, 2000);
        end

        // Button already held when reset is released counts as a press.
        rst = 1'b1; debounced = 1'b1;
        step(3);
        chk("hold_rst_count", int'(press_count), 0);
        rst = 1'b0;
        step(1);
        chk("rel_press_pulse", int'(press_pulse), 1);
        chk("rel_press_count", int'(press_count), 1);
        debounced = 1'b0;
        step(1100);

        // Reset in the middle of a hold must cancel the pending long press.
        begin
            int sl;
            debounced = 1'b1;
            step(1500);
            sl  = n_long;
            rst = 1'b1;
            step(1);
            chk("midhold_press",   int'(press_pulse),   0);
            chk("midhold_release", int'(release_pulse), 0);
            chk("midhold_long",    int'(long_press),    0);
            chk("midhold_count",   int'(press_count),   0);
            debounced = 1'b0;
            step(1);
            rst = 1'b0;
            step(1000);
            chk("midhold_no_long",  n_long - sl,        0);
            chk("midhold_count2",   int'(press_count),  0);
        end

        // Press counter wrap.
        for (int k = 0; k < 256; k++) begin
            debounced = 1'b1; step(5);
            debounced = 1'b0; step(5);
            if (k == 254) chk("wrap_count_255", int'(press_count), 255);
        end
        chk("wrap_count_0", int'(press_count), 0);
        step(1100);

        chk("press_release_overlap", overlap, 0);
        chk("dc_without_press",      dc_alone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
